mem_write_scoreboard: RTL and testbench

- Synthesizable, parametrised successor to the single-shot "write 25 to address 100" pass/fail check used in processor simulation.
- Watches the core's data-memory write port (MemWrite/DataAdr/WriteData) and matches writes, in order, against a programmable table of up to DEPTH expected (address, data) pairs.
- Can skip writes to a scratch address, enforces a cycle timeout, and reports pass/fail with a reason code.
- Sits beside the top-level core in benches and FPGA bring-up builds.

---
 rtl/mem_write_scoreboard.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_write_scoreboard.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_scoreboard.sv
// mem_write_scoreboard: in-order checker for a core's data-memory write port.
// A small table of expected (address, data) pairs is programmed while idle.
// After start, each observed write must match the next table entry, or hit
// the optional scratch address. Any other write, or running out of cycles,
// ends the check with a fail reason code.
module mem_write_scoreboard #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 4096,
  parameter int IGNORE_ADR = 96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [XLEN-1:0]          cfg_adr,
  input  logic [XLEN-1:0]          cfg_data,
  input  logic [$clog2(DEPTH):0]   cfg_num,
  input  logic                     ignore_en,
  input  logic                     start,
  input  logic                     MemWrite,
  input  logic [XLEN-1:0]          DataAdr,
  input  logic [XLEN-1:0]          WriteData,
  output logic                     busy,
  output logic                     pass,
  output logic                     fail,
  output logic [1:0]               fail_code,
  output logic [$clog2(DEPTH):0]   match_cnt,
  output logic [15:0]              ign_cnt,
  output logic [XLEN-1:0]          bad_adr,
  output logic [XLEN-1:0]          bad_data
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [XLEN-1:0] IGN_ADR   = XLEN'(IGNORE_ADR);
  localparam logic [TW-1:0]   CYC_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;
  localparam logic [1:0] FC_EMPTY    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  // Requested entry count limited to the table size.
  function automatic logic [CW-1:0] clamp_num(input logic [CW-1:0] n);
    if (n > DEPTH_CNT) begin
      return DEPTH_CNT;
    end else begin
      return n;
    end
  endfunction

  // Saturating increment for the scratch-write counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   num_q, num_d;
  logic [CW-1:0]   match_cnt_q, match_cnt_d;
  logic [15:0]     ign_cnt_q, ign_cnt_d;
  logic [TW-1:0]   cyc_q, cyc_d;
  logic [1:0]      fail_code_q, fail_code_d;
  logic [XLEN-1:0] bad_adr_q, bad_adr_d;
  logic [XLEN-1:0] bad_data_q, bad_data_d;
  logic            busy_q, pass_q, fail_q;

  logic [XLEN-1:0] exp_adr_q  [DEPTH];
  logic [XLEN-1:0] exp_data_q [DEPTH];

  logic [IW-1:0]   exp_idx_s;
  logic            hit_s;
  logic            last_s;
  logic            scratch_s;
  logic            tmo_s;

  // Decode of the current check: next entry, scratch hit, last entry, timeout edge.
  always_comb begin
    exp_idx_s = match_cnt_q[IW-1:0];
    hit_s     = (DataAdr == exp_adr_q[exp_idx_s]) && (WriteData == exp_data_q[exp_idx_s]);
    last_s    = (match_cnt_q == (num_q - CW'(1)));
    scratch_s = ignore_en && (DataAdr == IGN_ADR);
    tmo_s     = (cyc_q == CYC_LAST);
  end

  // Next-state and counter/capture logic; start wins over any check on the same edge.
  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    match_cnt_d = match_cnt_q;
    ign_cnt_d   = ign_cnt_q;
    cyc_d       = cyc_q;
    fail_code_d = fail_code_q;
    bad_adr_d   = bad_adr_q;
    bad_data_d  = bad_data_q;

    if (start) begin
      if (cfg_num == {CW{1'b0}}) begin
        state_d     = ST_FAIL;
        fail_code_d = FC_EMPTY;
      end else begin
        state_d     = ST_RUN;
        num_d       = clamp_num(cfg_num);
        match_cnt_d = {CW{1'b0}};
        ign_cnt_d   = 16'd0;
        cyc_d       = {TW{1'b0}};
        fail_code_d = FC_NONE;
        bad_adr_d   = {XLEN{1'b0}};
        bad_data_d  = {XLEN{1'b0}};
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          cyc_d = cyc_q + TW'(1);
          if (MemWrite && hit_s) begin
            match_cnt_d = match_cnt_q + CW'(1);
            if (last_s) begin
              state_d = ST_PASS;
            end else if (tmo_s) begin
              state_d     = ST_FAIL;
              fail_code_d = FC_TIMEOUT;
            end else begin
              state_d = ST_RUN;
            end
          end else if (MemWrite && scratch_s) begin
            ign_cnt_d = sat_inc16(ign_cnt_q);
            if (tmo_s) begin
              state_d     = ST_FAIL;
              fail_code_d = FC_TIMEOUT;
            end else begin
              state_d = ST_RUN;
            end
          end else if (MemWrite) begin
            state_d     = ST_FAIL;
            fail_code_d = FC_MISMATCH;
            bad_adr_d   = DataAdr;
            bad_data_d  = WriteData;
          end else if (tmo_s) begin
            state_d     = ST_FAIL;
            fail_code_d = FC_TIMEOUT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_IDLE, ST_PASS, ST_FAIL: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and status outputs; flags are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      num_q       <= {CW{1'b0}};
      match_cnt_q <= {CW{1'b0}};
      ign_cnt_q   <= 16'd0;
      cyc_q       <= {TW{1'b0}};
      fail_code_q <= FC_NONE;
      bad_adr_q   <= {XLEN{1'b0}};
      bad_data_q  <= {XLEN{1'b0}};
      busy_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      match_cnt_q <= match_cnt_d;
      ign_cnt_q   <= ign_cnt_d;
      cyc_q       <= cyc_d;
      fail_code_q <= fail_code_d;
      bad_adr_q   <= bad_adr_d;
      bad_data_q  <= bad_data_d;
      busy_q      <= (state_d == ST_RUN);
      pass_q      <= (state_d == ST_PASS);
      fail_q      <= (state_d == ST_FAIL);
    end
  end

  // Expected-write table; frozen while a check is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        exp_adr_q[i]  <= {XLEN{1'b0}};
        exp_data_q[i] <= {XLEN{1'b0}};
      end
    end else if (cfg_we && (state_q != ST_RUN)) begin
      exp_adr_q[cfg_idx]  <= cfg_adr;
      exp_data_q[cfg_idx] <= cfg_data;
    end
  end

  assign busy      = busy_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;
  assign match_cnt = match_cnt_q;
  assign ign_cnt   = ign_cnt_q;
  assign bad_adr   = bad_adr_q;
  assign bad_data  = bad_data_q;

endmodule

// File: tb/tb_mem_write_scoreboard.sv
// Bench for mem_write_scoreboard: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural reference model.
module tb_mem_write_scoreboard;

  localparam int TO     = 16;
  localparam int NDEPTH = 8;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PASS = 2;
  localparam int S_FAIL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_adr;
  logic [31:0] cfg_data;
  logic [3:0]  cfg_num;
  logic        ignore_en;
  logic        start;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        busy;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;
  logic [3:0]  match_cnt;
  logic [15:0] ign_cnt;
  logic [31:0] bad_adr;
  logic [31:0] bad_data;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          m_state;
  int          m_num, m_match, m_ign, m_cyc, m_code;
  logic [31:0] m_badadr, m_baddata;
  logic [31:0] t_adr  [NDEPTH];
  logic [31:0] t_data [NDEPTH];

  mem_write_scoreboard #(
    .XLEN(32), .DEPTH(NDEPTH), .TIMEOUT(TO), .IGNORE_ADR(96)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_adr(cfg_adr), .cfg_data(cfg_data), .cfg_num(cfg_num),
    .ignore_en(ignore_en), .start(start), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .busy(busy), .pass(pass),
    .fail(fail), .fail_code(fail_code), .match_cnt(match_cnt),
    .ign_cnt(ign_cnt), .bad_adr(bad_adr), .bad_data(bad_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_num = 0; m_match = 0; m_ign = 0; m_cyc = 0; m_code = 0;
    m_badadr = 32'd0; m_baddata = 32'd0;
    for (int i = 0; i < NDEPTH; i++) begin
      t_adr[i] = 32'd0; t_data[i] = 32'd0;
    end
  endtask

  // Apply the scoreboard rules to the inputs present at the coming edge.
  task automatic model_step();
    bit out_of_time;
    if (cfg_we && m_state != S_RUN) begin
      t_adr[cfg_idx]  = cfg_adr;
      t_data[cfg_idx] = cfg_data;
    end
    if (start) begin
      if (cfg_num == 4'd0) begin
        m_state = S_FAIL; m_code = 3;
      end else begin
        m_state = S_RUN;
        m_num = (int'(cfg_num) > NDEPTH) ? NDEPTH : int'(cfg_num);
        m_match = 0; m_ign = 0; m_cyc = 0; m_code = 0;
        m_badadr = 32'd0; m_baddata = 32'd0;
      end
    end else if (m_state == S_RUN) begin
      out_of_time = (m_cyc == TO - 1);
      m_cyc++;
      if (MemWrite && DataAdr == t_adr[m_match] && WriteData == t_data[m_match]) begin
        m_match++;
        if (m_match == m_num) m_state = S_PASS;
        else if (out_of_time) begin m_state = S_FAIL; m_code = 2; end
      end else if (MemWrite && ignore_en && DataAdr == 32'd96) begin
        if (m_ign < 65535) m_ign++;
        if (out_of_time) begin m_state = S_FAIL; m_code = 2; end
      end else if (MemWrite) begin
        m_state = S_FAIL; m_code = 1; m_badadr = DataAdr; m_baddata = WriteData;
      end else if (out_of_time) begin
        m_state = S_FAIL; m_code = 2;
      end
    end
  endtask

  task automatic check_all();
    check_eq("busy",      32'(busy),      32'(m_state == S_RUN));
    check_eq("pass",      32'(pass),      32'(m_state == S_PASS));
    check_eq("fail",      32'(fail),      32'(m_state == S_FAIL));
    check_eq("fail_code", 32'(fail_code), 32'(m_code));
    check_eq("match_cnt", 32'(match_cnt), 32'(m_match));
    check_eq("ign_cnt",   32'(ign_cnt),   32'(m_ign));
    check_eq("bad_adr",   bad_adr,        m_badadr);
    check_eq("bad_data",  bad_data,       m_baddata);
  endtask

  // One clock: model, edge, compare, then drop the one-shot inputs.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0; MemWrite = 1'b0;
    DataAdr = $urandom; WriteData = $urandom;
  endtask

  task automatic prog(input int idx, input logic [31:0] adr, input logic [31:0] dat);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_adr = adr; cfg_data = dat;
    tick();
  endtask

  task automatic go(input int num);
    start = 1'b1; cfg_num = 4'(num);
    tick();
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    MemWrite = 1'b1; DataAdr = adr; WriteData = dat;
    tick();
  endtask

  function automatic logic [31:0] pick_adr();
    case ($urandom_range(0, 3))
      0: return 32'd96;
      1: return 32'd100;
      2: return 32'h10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int r, n;
    reset = 1'b1; cfg_we = 1'b0; cfg_idx = 3'd0; cfg_adr = 32'd0; cfg_data = 32'd0;
    cfg_num = 4'd0; ignore_en = 1'b0; start = 1'b0; MemWrite = 1'b0;
    DataAdr = 32'd0; WriteData = 32'd0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // scratch writes skipped, then the expected write passes
    prog(0, 32'd100, 32'd25);
    ignore_en = 1'b1;
    go(1);
    wr(32'd96, 32'd7);
    wr(32'd96, 32'd9);
    wr(32'd100, 32'd25);
    check_eq("tp1_pass", 32'(pass), 32'd1);
    check_eq("tp1_ign", 32'(ign_cnt), 32'd2);
    check_eq("tp1_code", 32'(fail_code), 32'd0);

    // scratch write without skipping is a mismatch
    ignore_en = 1'b0;
    go(1);
    wr(32'd96, 32'd7);
    check_eq("tp2_fail", 32'(fail), 32'd1);
    check_eq("tp2_code", 32'(fail_code), 32'd1);
    check_eq("tp2_badadr", bad_adr, 32'd96);
    check_eq("tp2_baddata", bad_data, 32'd7);
    check_eq("tp2_match", 32'(match_cnt), 32'd0);

    // wrong data on the third entry
    prog(0, 32'h10, 32'd1);
    prog(1, 32'h14, 32'd2);
    prog(2, 32'h18, 32'd3);
    go(3);
    wr(32'h10, 32'd1);
    wr(32'h14, 32'd2);
    wr(32'h18, 32'd4);
    check_eq("tp3_code", 32'(fail_code), 32'd1);
    check_eq("tp3_match", 32'(match_cnt), 32'd2);
    check_eq("tp3_baddata", bad_data, 32'd4);

    // timeout exactly TO cycles after entering RUN
    go(1);
    repeat (TO - 1) tick();
    check_eq("tp4_busy_last", 32'(busy), 32'd1);
    tick();
    check_eq("tp4_fail", 32'(fail), 32'd1);
    check_eq("tp4_code", 32'(fail_code), 32'd2);
    // matching write on the timeout edge wins
    go(1);
    repeat (TO - 1) tick();
    wr(32'h10, 32'd1);
    check_eq("tp4_pass", 32'(pass), 32'd1);
    check_eq("tp4_nofail", 32'(fail), 32'd0);

    // empty table
    go(0);
    check_eq("tp5_code", 32'(fail_code), 32'd3);
    check_eq("tp5_busy", 32'(busy), 32'd0);

    // async reset in the middle of a run
    go(3);
    wr(32'h10, 32'd1);
    check_eq("tp6_match1", 32'(match_cnt), 32'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    check_eq("tp6_rst_busy", 32'(busy), 32'd0);
    check_eq("tp6_rst_match", 32'(match_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    prog(0, 32'h10, 32'd1);
    prog(1, 32'h14, 32'd2);
    prog(2, 32'h18, 32'd3);
    go(3);
    wr(32'h10, 32'd1);
    wr(32'h14, 32'd2);
    wr(32'h18, 32'd3);
    check_eq("tp6_pass", 32'(pass), 32'd1);

    // randomized traffic
    for (int it = 0; it < 1500; it++) begin
      r = int'($urandom_range(0, 99));
      if (m_state != S_RUN) begin
        if (r < 50) begin
          cfg_we = 1'b1; cfg_idx = 3'($urandom_range(0, 7));
          cfg_adr = pick_adr(); cfg_data = 32'($urandom_range(0, 3));
        end
        if (r >= 35 && r < 70) begin
          n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 10));
          start = 1'b1; cfg_num = 4'(n); ignore_en = 1'($urandom_range(0, 1));
        end
        if (r >= 90) begin
          MemWrite = 1'b1; DataAdr = pick_adr(); WriteData = 32'($urandom_range(0, 3));
        end
      end else begin
        if (r < 3) begin
          n = int'($urandom_range(0, 10));
          start = 1'b1; cfg_num = 4'(n);
          MemWrite = 1'b1; DataAdr = t_adr[m_match]; WriteData = t_data[m_match];
        end else if (r < 63) begin
          MemWrite = 1'b1; DataAdr = t_adr[m_match]; WriteData = t_data[m_match];
        end else if (r < 78) begin
          MemWrite = 1'b1; DataAdr = 32'd96; WriteData = $urandom;
        end else if (r < 86) begin
          MemWrite = 1'b1; DataAdr = pick_adr(); WriteData = 32'($urandom_range(0, 3));
        end else if (r >= 95) begin
          cfg_we = 1'b1; cfg_idx = 3'($urandom_range(0, 7));
          cfg_adr = $urandom; cfg_data = $urandom;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
